dmem_responder: RTL and testbench

Stalling data-memory responder on the far side of the processor's memory stage. It accepts the memory stage's per-cycle request (`Addr`, `DataIn`, `Rd`, `Wr`, `createdump`) and answers with `DataOut`, `Done` and `Stall`. A direct-mapped, write-back, write-allocate cache of one-word lines sits in front of a fixed-latency backing array. On a stall the processor freezes its pipeline registers and holds the request stable until `Done`.

---
 rtl/dmem_responder_if.sv | 23 ++
 rtl/dmem_responder.sv | 274 +++++++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the processor memory stage and the data-memory responder.
interface dmem_responder_if;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic        createdump;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        CacheHit;
  logic        err;

  modport master (
    output Addr, DataIn, Rd, Wr, createdump,
    input  DataOut, Done, Stall, CacheHit, err
  );

  modport slave (
    input  Addr, DataIn, Rd, Wr, createdump,
    output DataOut, Done, Stall, CacheHit, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Stalling data-memory responder: direct-mapped write-back cache of one-word lines
// in front of a fixed-latency backing array.
//   state  | meaning
//   IDLE   | accept request; hits complete here
//   WB     | writing dirty victim to backing array
//   FILL   | reading missed word from backing array
//   RESP   | completion cycle for a miss or a dump
//   DUMP   | scanning one line per cycle, flushing dirty lines
module dmem_responder #(
  parameter int IDX_W     = 3,
  parameter int LATENCY   = 4,
  parameter int MEM_WORDS = 32768
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);

  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 15 - IDX_W;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int MA_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [IDX_W-1:0] SCAN_LAST = IDX_W'(LINES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WB,
    S_FILL,
    S_RESP,
    S_DUMP
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:1]       req_addr_q, req_addr_d;
  logic [15:0]       req_data_q, req_data_d;
  logic              req_wr_q, req_wr_d;
  logic              dump_q, dump_d;
  logic [IDX_W-1:0]  scan_q, scan_d;

  logic              valid_q [LINES];
  logic              dirty_q [LINES];
  logic [TAG_W-1:0]  tag_q   [LINES];
  logic [15:0]       line_q  [LINES];
  logic [15:0]       backing_mem [MEM_WORDS];

  logic              line_we;
  logic [IDX_W-1:0]  line_widx;
  logic              line_wvalid;
  logic              line_wdirty;
  logic [TAG_W-1:0]  line_wtag;
  logic [15:0]       line_wdata;

  logic              mem_we;
  logic [MA_W-1:0]   mem_waddr;
  logic [15:0]       mem_wdata;
  logic [MA_W-1:0]   mem_raddr;

  logic [15:0]       data_out;
  logic              done;
  logic              stall;
  logic              cache_hit;
  logic              err;

  logic [IDX_W-1:0]  in_idx;
  logic [TAG_W-1:0]  in_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              any_req;
  logic              legal_rd;
  logic              legal_wr;
  logic              legal_dump;
  logic              hit;
  logic              victim_dirty;

  function automatic logic [MA_W-1:0] word_addr(input logic [14:0] w);
    return MA_W'(32'(w) % MEM_WORDS);
  endfunction

  assign in_idx   = bus.Addr[IDX_W:1];
  assign in_tag   = bus.Addr[15:IDX_W+1];
  assign req_idx  = req_addr_q[IDX_W:1];
  assign req_tag  = req_addr_q[15:IDX_W+1];

  assign any_req    = bus.Rd | bus.Wr | bus.createdump;
  assign legal_rd   = bus.Rd & ~bus.Wr & ~bus.createdump & ~bus.Addr[0];
  assign legal_wr   = bus.Wr & ~bus.Rd & ~bus.createdump & ~bus.Addr[0];
  assign legal_dump = bus.createdump & ~bus.Rd & ~bus.Wr;

  assign hit          = valid_q[in_idx] && (tag_q[in_idx] == in_tag);
  assign victim_dirty = valid_q[in_idx] && dirty_q[in_idx];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    req_wr_d    = req_wr_q;
    dump_d      = dump_q;
    scan_d      = scan_q;
    line_we     = 1'b0;
    line_widx   = '0;
    line_wvalid = 1'b0;
    line_wdirty = 1'b0;
    line_wtag   = '0;
    line_wdata  = '0;
    mem_we      = 1'b0;
    mem_waddr   = '0;
    mem_wdata   = '0;
    mem_raddr   = word_addr(req_addr_q);
    data_out    = '0;
    done        = 1'b0;
    stall       = 1'b0;
    cache_hit   = 1'b0;
    err         = 1'b0;

    // Reset suppresses every output and every write, including a pending WB.
    if (!rst) begin
      unique case (state_q)
        S_IDLE: begin
          if (legal_dump) begin
            stall   = 1'b1;
            scan_d  = '0;
            dump_d  = 1'b1;
            state_d = S_DUMP;
          end else if (legal_rd || legal_wr) begin
            if (hit) begin
              done      = 1'b1;
              cache_hit = 1'b1;
              if (legal_rd) begin
                data_out = line_q[in_idx];
              end else begin
                line_we     = 1'b1;
                line_widx   = in_idx;
                line_wvalid = 1'b1;
                line_wdirty = 1'b1;
                line_wtag   = in_tag;
                line_wdata  = bus.DataIn;
              end
            end else begin
              stall      = 1'b1;
              req_addr_d = bus.Addr[15:1];
              req_data_d = bus.DataIn;
              req_wr_d   = legal_wr;
              dump_d     = 1'b0;
              cnt_d      = CNT_INIT;
              state_d    = victim_dirty ? S_WB : S_FILL;
            end
          end else if (any_req) begin
            err = 1'b1;
          end
        end

        S_WB: begin
          stall = 1'b1;
          if (cnt_q == '0) begin
            mem_we    = 1'b1;
            mem_waddr = word_addr({tag_q[req_idx], req_idx});
            mem_wdata = line_q[req_idx];
            cnt_d     = CNT_INIT;
            state_d   = S_FILL;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end

        S_FILL: begin
          stall = 1'b1;
          if (cnt_q == '0) begin
            line_we     = 1'b1;
            line_widx   = req_idx;
            line_wvalid = 1'b1;
            line_wdirty = 1'b0;
            line_wtag   = req_tag;
            line_wdata  = backing_mem[mem_raddr];
            state_d     = S_RESP;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end

        S_RESP: begin
          done    = 1'b1;
          dump_d  = 1'b0;
          state_d = S_IDLE;
          if (!dump_q) begin
            if (req_wr_q) begin
              line_we     = 1'b1;
              line_widx   = req_idx;
              line_wvalid = 1'b1;
              line_wdirty = 1'b1;
              line_wtag   = req_tag;
              line_wdata  = req_data_q;
            end else begin
              data_out = line_q[req_idx];
            end
          end
        end

        S_DUMP: begin
          stall = 1'b1;
          if (valid_q[scan_q] && dirty_q[scan_q]) begin
            mem_we      = 1'b1;
            mem_waddr   = word_addr({tag_q[scan_q], scan_q});
            mem_wdata   = line_q[scan_q];
            line_we     = 1'b1;
            line_widx   = scan_q;
            line_wvalid = 1'b1;
            line_wdirty = 1'b0;
            line_wtag   = tag_q[scan_q];
            line_wdata  = line_q[scan_q];
          end
          if (scan_q == SCAN_LAST) begin
            state_d = S_RESP;
          end else begin
            scan_d = scan_q + 1'b1;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      req_addr_q <= '0;
      req_data_q <= '0;
      req_wr_q   <= 1'b0;
      dump_q     <= 1'b0;
      scan_q     <= '0;
      for (int i = 0; i < LINES; i++) begin
        valid_q[i] <= 1'b0;
        dirty_q[i] <= 1'b0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      req_wr_q   <= req_wr_d;
      dump_q     <= dump_d;
      scan_q     <= scan_d;
      if (line_we) begin
        valid_q[line_widx] <= line_wvalid;
        dirty_q[line_widx] <= line_wdirty;
      end
    end
  end

  // Tag/data storage needs no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[line_widx]  <= line_wtag;
      line_q[line_widx] <= line_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      backing_mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.DataOut  = data_out;
  assign bus.Done     = done;
  assign bus.Stall    = stall;
  assign bus.CacheHit = cache_hit;
  assign bus.err      = err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (IDX_W=3, LATENCY=4): latency, hit/miss,
// error, dump and reset-abort behaviour observed only through the ports.
module tb_dmem_responder;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  dmem_responder_if bus ();

  dmem_responder #(
    .IDX_W    (3),
    .LATENCY  (4),
    .MEM_WORDS(32768)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.Rd         = 1'b0;
    bus.Wr         = 1'b0;
    bus.createdump = 1'b0;
    bus.Addr       = '0;
    bus.DataIn     = '0;
  endtask

  // Hold a request until Done; expected latency is the cycle index of Done.
  task automatic req(input string tag, input logic rd, input logic wr, input logic dmp,
                     input logic [15:0] addr, input logic [15:0] din,
                     input int exp_lat, input logic exp_hit, input logic [15:0] exp_dout);
    int          lat;
    int          nstall;
    logic        both;
    logic [15:0] dout;
    logic        hit;
    lat = -1; nstall = 0; both = 1'b0; dout = '0; hit = 1'b0;
    bus.Rd = rd; bus.Wr = wr; bus.createdump = dmp; bus.Addr = addr; bus.DataIn = din;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.Done && bus.Stall) both = 1'b1;
      if (bus.Stall) nstall++;
      if (bus.Done) begin
        lat  = c;
        dout = bus.DataOut;
        hit  = bus.CacheHit;
        break;
      end
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_stall"}, nstall, exp_lat);
    chk({tag, "_hit"}, {31'b0, hit}, {31'b0, exp_hit});
    chk({tag, "_dout"}, {16'b0, dout}, {16'b0, exp_dout});
    chk({tag, "_overlap"}, {31'b0, both}, 32'd0);
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic err_probe(input string tag, input logic rd, input logic wr, input logic dmp,
                           input logic [15:0] addr);
    bus.Rd = rd; bus.Wr = wr; bus.createdump = dmp; bus.Addr = addr; bus.DataIn = 16'hDEAD;
    @(negedge clk);
    chk(tag, {29'b0, bus.err, bus.Done, bus.Stall}, {29'b0, 3'b100});
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    bus.Rd   = 1'b1;
    bus.Addr = 16'h0010;
    @(negedge clk);
    chk("reset_outputs", {bus.DataOut, 12'b0, bus.Done, bus.Stall, bus.CacheHit, bus.err}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();

    // Cold read, store hit, load hit.
    req("cold_rd",  1, 0, 0, 16'h0010, 16'h0000, 5, 0, 16'h0000);
    req("wr_hit",   0, 1, 0, 16'h0010, 16'hBEEF, 0, 1, 16'h0000);
    req("rd_hit",   1, 0, 0, 16'h0010, 16'h0000, 0, 1, 16'hBEEF);

    err_probe("err_rdwr",  1, 1, 0, 16'h0010);
    err_probe("err_odd",   1, 0, 0, 16'h0011);
    err_probe("err_dumprd", 1, 0, 1, 16'h0010);
    req("after_err", 1, 0, 0, 16'h0010, 16'h0000, 0, 1, 16'hBEEF);

    // Dirty conflict on index 0, then refetch the written-back word.
    req("dirty_miss", 1, 0, 0, 16'h0020, 16'h0000, 9, 0, 16'h0000);
    req("refetch",    1, 0, 0, 16'h0010, 16'h0000, 5, 0, 16'hBEEF);

    // Three dirty lines, then dump.
    req("wr_a", 0, 1, 0, 16'h0012, 16'h1111, 5, 0, 16'h0000);
    req("wr_b", 0, 1, 0, 16'h0014, 16'h2222, 5, 0, 16'h0000);
    req("wr_c", 0, 1, 0, 16'h0016, 16'h3333, 5, 0, 16'h0000);
    req("b2b_a", 1, 0, 0, 16'h0012, 16'h0000, 0, 1, 16'h1111);
    req("b2b_b", 1, 0, 0, 16'h0014, 16'h0000, 0, 1, 16'h2222);
    req("dump",  0, 0, 1, 16'h0000, 16'h0000, 9, 0, 16'h0000);

    // Clean evictions prove dirty bits cleared; refetches prove backing holds the data.
    req("evict_a", 1, 0, 0, 16'h0032, 16'h0000, 5, 0, 16'h0000);
    req("back_a",  1, 0, 0, 16'h0012, 16'h0000, 5, 0, 16'h1111);
    req("evict_b", 1, 0, 0, 16'h0034, 16'h0000, 5, 0, 16'h0000);
    req("back_b",  1, 0, 0, 16'h0014, 16'h0000, 5, 0, 16'h2222);
    req("evict_c", 1, 0, 0, 16'h0036, 16'h0000, 5, 0, 16'h0000);
    req("back_c",  1, 0, 0, 16'h0016, 16'h0000, 5, 0, 16'h3333);

    // Reset during the second WB cycle must abort the writeback.
    req("wr_victim", 0, 1, 0, 16'h0018, 16'hAAAA, 5, 0, 16'h0000);
    bus.Rd   = 1'b1;
    bus.Addr = 16'h0038;
    repeat (3) @(negedge clk);
    chk("wb_stall_c2", {31'b0, bus.Stall}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    idle_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    req("post_rst_victim", 1, 0, 0, 16'h0018, 16'h0000, 5, 0, 16'h0000);
    req("post_rst_0010",   1, 0, 0, 16'h0010, 16'h0000, 5, 0, 16'hBEEF);
    req("post_rst_0012",   1, 0, 0, 16'h0012, 16'h0000, 5, 0, 16'h1111);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
